// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Provides the FSM state enum, instruction size and the prefetch entry layout.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } ifu_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int IFU_ADDR_W  = 32;
    localparam int IFU_DATA_W  = 32;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO: DEPTH-entry synchronous FIFO with push, pop, flush and count.
// Ports: clk, rst_n, push_i, pop_i, flush_i, wdata_i, rdata_o (head), empty_o, full_o, count_o.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(fetch_entry_t),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;

    // Storage needs no reset: entries are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, buffers in a prefetch FIFO.
// Ports: clk/rst_n; imem_req/addr/gnt/rvalid/rdata; redirect_valid/pc; if_valid/ready/instr/pc.
// Option: define IFU_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter int                DATA_W   = IFU_DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ifu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;

    logic [ADDR_W-1:0] redir_pc;
    logic              word_ok;
    logic              byp_hit;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  cnt_after;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic              unused_redir_lsb;

    assign redir_pc         = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redir_lsb = ^redirect_pc[1:0];

    // A returning word is kept only if nothing redirected the stream this cycle.
    assign word_ok = (state_q == WAIT) && imem_rvalid && !redirect_valid;

`ifdef IFU_BYPASS_EN
    assign byp_hit = word_ok && fifo_empty;
`else
    assign byp_hit = 1'b0;
`endif

    assign pop  = !fifo_empty && if_ready;
    assign push = word_ok && !(byp_hit && if_ready);

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

    assign cnt_after = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect_valid) begin
            pc_d = redir_pc;
        end
        unique case (state_q)
            IDLE: begin
                // A redirect flushes the FIFO, so there is room next cycle.
                if (!fifo_full || redirect_valid) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    if (redirect_valid) begin
                        state_d = DROP;
                    end else begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + ADDR_W'(INSTR_BYTES);
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        state_d = REQ;
                    end else if (cnt_after < CNT_W'(DEPTH)) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == REQ);
        imem_addr = pc_q;
        if_valid  = !fifo_empty;
        if_instr  = '0;
        if_pc     = '0;
        if (!fifo_empty) begin
            if_instr = head_entry.instr;
            if_pc    = head_entry.pc;
        end
`ifdef IFU_BYPASS_EN
        else if (byp_hit) begin
            if_valid = 1'b1;
            if_instr = imem_rdata;
            if_pc    = req_pc_q;
        end
`endif
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: randomized memory, ready and redirects.
// A PC-stream scoreboard checks every delivered beat and every granted fetch address.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    int lat_min = 1;
    int lat_max = 1;
    int gnt_pct = 100;

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: one outstanding request, latency lat_min..lat_max.
    initial begin
        logic        busy;
        int          cnt;
        logic [31:0] addr;
        busy = 1'b0;
        cnt = 0;
        addr = '0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_gnt = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata = $urandom;
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata = memf(addr);
                        busy = 1'b0;
                    end
                end
                if (imem_req && !busy && ($urandom % 100) < gnt_pct) begin
                    imem_gnt = 1'b1;
                    busy = 1'b1;
                    addr = imem_addr;
                    cnt = $urandom_range(lat_max, lat_min);
                end
            end
        end
    end

    // Scoreboard: decode must see a contiguous PC stream restarting at each redirect target.
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_fetch;
        logic        redir_prev;
        exp_pc = RST_PC;
        exp_fetch = RST_PC;
        redir_prev = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                exp_pc = RST_PC;
                exp_fetch = RST_PC;
                redir_prev = 1'b0;
            end else begin
                if (redir_prev) begin
                    checks++;
                    if (if_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL flush_valid t=%0t if_valid=%b required 0", $time, if_valid);
                    end
                end
                if (if_valid && if_ready) begin
                    hs_cnt++;
                    checks++;
                    if (if_pc !== exp_pc || if_instr !== memf(exp_pc)) begin
                        errors++;
                        $display("FAIL beat t=%0t pc=%h instr=%h required pc=%h instr=%h",
                                 $time, if_pc, if_instr, exp_pc, memf(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                end
                if (imem_req && imem_gnt) begin
                    checks++;
                    if (imem_addr !== exp_fetch) begin
                        errors++;
                        $display("FAIL fetch_addr t=%0t addr=%h required %h", $time, imem_addr, exp_fetch);
                    end
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (redirect_valid) begin
                    exp_pc = {redirect_pc[31:2], 2'b00};
                    exp_fetch = {redirect_pc[31:2], 2'b00};
                end
                redir_prev = redirect_valid;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        if_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #4;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || if_valid !== 1'b0 ||
            if_instr !== '0 || if_pc !== '0) begin
            errors++;
            $display("FAIL reset_outputs req=%b addr=%h valid=%b instr=%h pc=%h required 0,%h,0,0,0",
                     imem_req, imem_addr, if_valid, if_instr, if_pc, RST_PC);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #4;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req req=%b addr=%h required 1,%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int h0;
        lat_min = 1;
        lat_max = 1;
        gnt_pct = 100;
        do_reset();
        @(negedge clk);
        if_ready = 1'b1;
        h0 = hs_cnt;
        repeat (40) @(negedge clk);
        #4;
        checks++;
        if (hs_cnt - h0 < 16) begin
            errors++;
            $display("FAIL stream_rate beats=%0d required >=16", hs_cnt - h0);
        end
    endtask

    task automatic test_backpressure();
        int g;
        int h0;
        int n;
        lat_min = 1;
        lat_max = 1;
        gnt_pct = 100;
        do_reset();
        g = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #4;
            if (imem_req && imem_gnt) g++;
        end
        checks++;
        if (g != 4 || imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL full_stall grants=%0d req=%b valid=%b pc=%h required 4,0,1,0",
                     g, imem_req, if_valid, if_pc);
        end
        @(negedge clk);
        if_ready = 1'b1;
        h0 = hs_cnt;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            #4;
            if (imem_req && imem_gnt) break;
            n++;
        end
        checks++;
        if (n >= 40 || imem_addr !== 32'd16) begin
            errors++;
            $display("FAIL resume_addr addr=%h timeout=%0d required 00000010", imem_addr, n >= 40);
        end
        repeat (12) @(negedge clk);
        #4;
        checks++;
        if (hs_cnt - h0 < 4) begin
            errors++;
            $display("FAIL drain beats=%0d required >=4", hs_cnt - h0);
        end
    endtask

    task automatic test_redirect_wait();
        int n;
        int t;
        lat_min = 3;
        lat_max = 3;
        gnt_pct = 100;
        do_reset();
        n = 0;
        t = 0;
        while (n < 2 && t < 50) begin
            @(negedge clk);
            #4;
            if (imem_req && imem_gnt) n++;
            t++;
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        #4;
        checks++;
        if (t >= 50 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_redirect valid=%b timeout=%0d required 1", if_valid, t >= 50);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        #4;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_redirect_empty valid=%b required 0", if_valid);
        end
        t = 0;
        while (t < 40) begin
            @(negedge clk);
            #4;
            if (if_valid && if_ready) break;
            t++;
        end
        checks++;
        if (t >= 40 || if_pc !== 32'h100 || if_instr !== memf(32'h100)) begin
            errors++;
            $display("FAIL redirect_target pc=%h instr=%h required 00000100 %h",
                     if_pc, if_instr, memf(32'h100));
        end
    endtask

    task automatic test_redirect_edges();
        int t;
        lat_min = 2;
        lat_max = 2;
        gnt_pct = 100;
        do_reset();
        if_ready = 1'b1;
        t = 0;
        while (t < 40) begin
            @(negedge clk);
            #1;
            if (imem_gnt) break;
            t++;
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h2000;
        @(negedge clk);
        redirect_valid = 1'b0;
        t = 0;
        while (t < 40) begin
            @(negedge clk);
            #4;
            if (if_valid && if_ready) break;
            t++;
        end
        checks++;
        if (t >= 40 || if_pc !== 32'h2000) begin
            errors++;
            $display("FAIL redirect_on_gnt pc=%h required 00002000", if_pc);
        end
        t = 0;
        while (t < 40) begin
            @(negedge clk);
            #1;
            if (imem_rvalid) break;
            t++;
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000;
        @(negedge clk);
        redirect_valid = 1'b0;
        t = 0;
        while (t < 40) begin
            @(negedge clk);
            #4;
            if (if_valid && if_ready) break;
            t++;
        end
        checks++;
        if (t >= 40 || if_pc !== 32'h3000) begin
            errors++;
            $display("FAIL redirect_on_rvalid pc=%h required 00003000", if_pc);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int t;
        lat_min = 3;
        lat_max = 3;
        gnt_pct = 100;
        do_reset();
        n = 0;
        t = 0;
        while (n < 3 && t < 60) begin
            @(negedge clk);
            #4;
            if (imem_req && imem_gnt) n++;
            t++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (t >= 60 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_buffered valid=%b required 1", if_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset valid=%b req=%b required 0,0", if_valid, imem_req);
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        if_ready = 1'b1;
        t = 0;
        while (t < 40) begin
            @(negedge clk);
            #4;
            if (if_valid && if_ready) break;
            t++;
        end
        checks++;
        if (t >= 40 || if_pc !== RST_PC) begin
            errors++;
            $display("FAIL refetch_after_reset pc=%h required %h", if_pc, RST_PC);
        end
    endtask

    task automatic test_wrap();
        int t;
        logic [31:0] pcs [2];
        lat_min = 1;
        lat_max = 2;
        gnt_pct = 100;
        do_reset();
        if_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pcs[k] = 32'h1;
            t = 0;
            while (t < 40) begin
                @(negedge clk);
                #4;
                if (if_valid && if_ready) break;
                t++;
            end
            if (t < 40) pcs[k] = if_pc;
        end
        checks++;
        if (pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap pcs=%h,%h required fffffffc,00000000", pcs[0], pcs[1]);
        end
    endtask

    task automatic test_bypass();
        int t;
        lat_min = 1;
        lat_max = 1;
        gnt_pct = 100;
        do_reset();
        @(negedge clk);
        if_ready = 1'b1;
        t = 0;
        while (t < 40) begin
            @(negedge clk);
            #4;
            if (imem_rvalid) break;
            t++;
        end
`ifdef IFU_BYPASS_EN
        checks++;
        if (t >= 40 || if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== memf(RST_PC)) begin
            errors++;
            $display("FAIL bypass_same_cycle valid=%b pc=%h required 1,%h", if_valid, if_pc, RST_PC);
        end
`else
        checks++;
        if (t >= 40 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL registered_rvalid_cycle valid=%b required 0", if_valid);
        end
        @(negedge clk);
        #4;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== memf(RST_PC)) begin
            errors++;
            $display("FAIL registered_next_cycle valid=%b pc=%h required 1,%h", if_valid, if_pc, RST_PC);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int h0;
        lat_min = 1;
        lat_max = 4;
        gnt_pct = 60;
        do_reset();
        h0 = hs_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if_ready = ($urandom % 100) < 70;
            redirect_valid = ($urandom % 100) < 3;
            if ($urandom % 4 == 0) begin
                redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
            end else begin
                redirect_pc = $urandom;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        #4;
        checks++;
        if (hs_cnt - h0 < 100) begin
            errors++;
            $display("FAIL random_throughput beats=%0d required >=100", hs_cnt - h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_edges();
        test_reset_mid_wait();
        test_wrap();
        test_bypass();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
